// File: rtl/sync_fifo_pkg.sv
// Shared types, defaults and helpers for the single-clock FIFO controller.
package sync_fifo_pkg;

   localparam int unsigned DEF_FIFO_DEPTH    = 8;
   localparam int unsigned DEF_PTR_WIDTH     = 3;
   localparam int unsigned DEF_AFULL_THRESH  = 6;
   localparam int unsigned DEF_AEMPTY_THRESH = 2;

   // Pointer at the default geometry: address bits plus one wrap bit.
   typedef logic [DEF_PTR_WIDTH:0] ptr_t;

   // Occupancy from two wrap-bit pointers, modulo twice the depth.
   function automatic logic [31:0] ptr_diff(input logic [31:0] wp,
                                            input logic [31:0] rp,
                                            input int unsigned depth);
      return (wp - rp) & ((depth << 1) - 32'd1);
   endfunction

endpackage

// File: rtl/sync_fifo_ctrl_fifo_ptr.sv
// Free-running wrapping pointer with wrap bit in the MSB.
module fifo_ptr
   import sync_fifo_pkg::*;
#(
   parameter int unsigned PTR_WIDTH = DEF_PTR_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inc,
   output logic [PTR_WIDTH:0] ptr
);

   localparam int unsigned PW1 = PTR_WIDTH + 1;

   logic [PTR_WIDTH:0] ptr_q;
   logic [PTR_WIDTH:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc) ptr_d = ptr_q + PW1'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, memory write enable and status.
// Optional sticky overflow/underflow flags with `SYNC_FIFO_ERR_EN.
module sync_fifo_ctrl
   import sync_fifo_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
   parameter int unsigned PTR_WIDTH     = DEF_PTR_WIDTH,
   parameter int unsigned AFULL_THRESH  = DEF_AFULL_THRESH,
   parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic               rd_en,
   output logic               wclken,
   output logic [PTR_WIDTH:0] waddr,
   output logic [PTR_WIDTH:0] raddr,
   output logic               full,
   output logic               empty,
   output logic               almost_full,
   output logic               almost_empty,
`ifdef SYNC_FIFO_ERR_EN
   output logic               overflow,
   output logic               underflow,
   input  logic               err_clr,
`endif
   output logic [PTR_WIDTH:0] count
);

   localparam int unsigned PW1 = PTR_WIDTH + 1;

   logic [PTR_WIDTH:0] wptr;
   logic [PTR_WIDTH:0] rptr;
   logic               push;
   logic               pop;

   // Requests are gated per side by the registered status only.
   assign push = wr_en & ~full;
   assign pop  = rd_en & ~empty;

   fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_wptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push),
      .ptr   (wptr)
   );

   fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_rptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pop),
      .ptr   (rptr)
   );

   assign wclken = push;
   assign waddr  = wptr;
   assign raddr  = rptr;

   // Full when the laps differ but the addresses coincide.
   assign full  = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                  (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
   assign empty = (wptr == rptr);
   assign count = PW1'(ptr_diff(32'(wptr), 32'(rptr), FIFO_DEPTH));

   assign almost_full  = (32'(count) >= AFULL_THRESH);
   assign almost_empty = (32'(count) <= AEMPTY_THRESH);

`ifdef SYNC_FIFO_ERR_EN
   logic overflow_q;
   logic overflow_d;
   logic underflow_q;
   logic underflow_d;

   // Sticky flags; a new error in the clearing cycle wins over the clear.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wr_en && full)  overflow_d  = 1'b1;
      if (rd_en && empty) underflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a behavioural storage array beside it.
module tb_sync_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic       rd_en;
   logic       wclken;
   logic [3:0] waddr;
   logic [3:0] raddr;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [3:0] count;
`ifdef SYNC_FIFO_ERR_EN
   logic       overflow;
   logic       underflow;
   logic       err_clr;
`endif

   logic [7:0] wdata;
   logic [7:0] rdata;
   logic [7:0] mem [8];

   int total = 0;
   int bad   = 0;

   // Reference model state
   int         cnt;
   int         wp;
   int         rp;
   logic [7:0] q [$];

   sync_fifo_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .wclken       (wclken),
      .waddr        (waddr),
      .raddr        (raddr),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
`ifdef SYNC_FIFO_ERR_EN
      .overflow     (overflow),
      .underflow    (underflow),
      .err_clr      (err_clr),
`endif
      .count        (count)
   );

   always #5 clk = ~clk;

   // Storage array the controller sequences: write on wclken, FWFT read.
   always @(posedge clk) if (wclken) mem[waddr[2:0]] <= wdata;
   assign rdata = mem[raddr[2:0]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      cnt = 0;
      wp  = 0;
      rp  = 0;
      q.delete();
   endtask

   // One cycle of stimulus, starting just after a rising edge.
   task automatic step(input bit w, input bit r, input logic [7:0] d);
      bit aw;
      bit ar;
      wr_en = w;
      rd_en = r;
      wdata = d;
      #1;
      aw = w && (cnt < 8);
      ar = r && (cnt > 0);
      chk("wclken", 32'(wclken), 32'(aw));
      if (ar) chk("rdata", 32'(rdata), 32'(q[0]));
      @(posedge clk);
      #1;
      if (ar) void'(q.pop_front());
      if (aw) q.push_back(d);
      cnt = cnt + int'(aw) - int'(ar);
      wp  = (wp + int'(aw)) % 16;
      rp  = (rp + int'(ar)) % 16;
      chk("count",  32'(count),        32'(cnt));
      chk("full",   32'(full),         32'(cnt == 8));
      chk("empty",  32'(empty),        32'(cnt == 0));
      chk("afull",  32'(almost_full),  32'(cnt >= 6));
      chk("aempty", 32'(almost_empty), 32'(cnt <= 2));
      chk("waddr",  32'(waddr),        32'(wp));
      chk("raddr",  32'(raddr),        32'(rp));
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      wdata = 8'h00;
`ifdef SYNC_FIFO_ERR_EN
      err_clr = 1'b0;
`endif
      model_reset();
      #2;
      chk("rst_waddr",  32'(waddr),        32'd0);
      chk("rst_raddr",  32'(raddr),        32'd0);
      chk("rst_count",  32'(count),        32'd0);
      chk("rst_empty",  32'(empty),        32'd1);
      chk("rst_full",   32'(full),         32'd0);
      chk("rst_aempty", 32'(almost_empty), 32'd1);
      chk("rst_afull",  32'(almost_full),  32'd0);
      chk("rst_wclken", 32'(wclken),       32'd0);
`ifdef SYNC_FIFO_ERR_EN
      chk("rst_ovf", 32'(overflow),  32'd0);
      chk("rst_unf", 32'(underflow), 32'd0);
`endif
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;

      // Fill 0x10..0x17
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_count", 32'(count), 32'd8);
      step(1'b1, 1'b0, 8'h18);
      chk("ovr_waddr", 32'(waddr), 32'd8);
`ifdef SYNC_FIFO_ERR_EN
      chk("ovf_set", 32'(overflow), 32'd1);
`endif

      // Drain, checking data order through the model queue
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b0;
         #0;
         chk("drain_data", 32'(rdata), 32'(8'h10 + i));
         step(1'b0, 1'b1, 8'h00);
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_count", 32'(count), 32'd0);
      step(1'b0, 1'b1, 8'h00);
      chk("udr_raddr", 32'(raddr), 32'd8);
`ifdef SYNC_FIFO_ERR_EN
      chk("unf_set", 32'(underflow), 32'd1);
      step(1'b0, 1'b0, 8'h00);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      err_clr = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      err_clr = 1'b0;
      chk("ovf_clr", 32'(overflow),  32'd0);
      chk("unf_clr", 32'(underflow), 32'd0);
`endif

      // Steady-state streaming at count 3 across the pointer wrap
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(8'h30 + i));
      chk("stream_count", 32'(count), 32'd3);
      chk("stream_waddr", 32'(waddr), 32'd15);
      chk("stream_raddr", 32'(raddr), 32'd12);

      // Simultaneous push/pop at full: pop only
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h50 + i));
      chk("pre_full", 32'(full), 32'd1);
      step(1'b1, 1'b1, 8'h60);
      chk("full_rw_count", 32'(count), 32'd7);
      chk("full_rw_full",  32'(full),  32'd0);

      // Simultaneous push/pop at empty: push only, word falls through
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00);
      chk("pre_empty", 32'(empty), 32'd1);
      step(1'b1, 1'b1, 8'h77);
      chk("empty_rw_count", 32'(count), 32'd1);
      chk("empty_rw_empty", 32'(empty), 32'd0);
      chk("empty_rw_rdata", 32'(rdata), 32'h77);

      // Asynchronous reset at count 5, checked before any clock edge
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
      chk("pre_rst_count", 32'(count), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_waddr", 32'(waddr), 32'd0);
      chk("arst_raddr", 32'(raddr), 32'd0);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;

`ifdef SYNC_FIFO_ERR_EN
      // A new overflow in the clearing cycle keeps the flag set
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h90 + i));
      err_clr = 1'b1;
      step(1'b1, 1'b0, 8'hA0);
      err_clr = 1'b0;
      chk("ovf_set_wins", 32'(overflow), 32'd1);
`else
      step(1'b1, 1'b0, 8'hA5);
      chk("post_rst_rdata", 32'(rdata), 32'hA5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
